bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_arbiter_if.sv | 56 +++++
 rtl/bus_arbiter_rr_priority_encoder.sv | 33 +++
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, arbiter state encoding and abort data for the cart bus
//
// Purpose: common definitions imported by the bus arbiter, its interface and its
// priority encoder. No ports.
package bus_pkg;

    localparam int BANK_W = 4;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;

    // Read data returned to the owner when the watchdog gives up on a read.
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester-side and cart-bus-side signal bundle of the arbiter
//
// Purpose: groups every handshake/bus signal of bus_arbiter. Names are taken from
// the arbiter's point of view (i_* enter the arbiter, o_* leave it).
// Modports:
//   master - the arbiter itself, which masters the shared cart bus
//   slave  - the environment: requesters plus the cart bus target
// Signals (N = NUM_MASTERS):
//   i_enable[N], i_m_request[N], i_m_write[N], i_m_bank[4N], i_m_address[26N],
//   i_m_data[32N]                          requester commands
//   o_m_busy[N], o_m_ack[N], o_m_data[32]  requester responses
//   o_request, o_write, o_bank, o_address, o_data   bus command
//   i_busy, i_ack, i_data                  bus response
//   o_timeout                              watchdog abort pulse
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 3
);
    localparam int N = NUM_MASTERS;

    logic [N-1:0]        i_enable;
    logic [N-1:0]        i_m_request;
    logic [N-1:0]        i_m_write;
    logic [BANK_W*N-1:0] i_m_bank;
    logic [ADDR_W*N-1:0] i_m_address;
    logic [DATA_W*N-1:0] i_m_data;
    logic [N-1:0]        o_m_busy;
    logic [N-1:0]        o_m_ack;
    logic [DATA_W-1:0]   o_m_data;

    logic                o_request;
    logic                o_write;
    logic [BANK_W-1:0]   o_bank;
    logic [ADDR_W-1:0]   o_address;
    logic [DATA_W-1:0]   o_data;
    logic                i_busy;
    logic                i_ack;
    logic [DATA_W-1:0]   i_data;
    logic                o_timeout;

    modport master (
        input  i_enable, i_m_request, i_m_write, i_m_bank, i_m_address, i_m_data,
        input  i_busy, i_ack, i_data,
        output o_m_busy, o_m_ack, o_m_data,
        output o_request, o_write, o_bank, o_address, o_data, o_timeout
    );

    modport slave (
        output i_enable, i_m_request, i_m_write, i_m_bank, i_m_address, i_m_data,
        output i_busy, i_ack, i_data,
        input  o_m_busy, o_m_ack, o_m_data,
        input  o_request, o_write, o_bank, o_address, o_data, o_timeout
    );

endinterface

// File: rtl/bus_arbiter_rr_priority_encoder.sv
// rtl/bus_arbiter_rr_priority_encoder.sv - round-robin pick of the next eligible requester
//
// Purpose: combinational search for the first set bit of eligible_i starting one
// above last_i and wrapping modulo N.
// Ports:
//   eligible_i[N]  requesters that may be granted
//   last_i[IW]     index granted most recently
//   winner_o[IW]   chosen index (0 when none)
//   valid_o        a winner exists
module rr_priority_encoder #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        // Offsets 1..N visit every index once, ending on last_i itself so a lone
        // requester can be granted back to back.
        for (int i = 1; i <= N; i++) begin
            if (!valid_o && eligible_i[(int'(last_i) + i) % N]) begin
                valid_o  = 1'b1;
                winner_o = IW'((int'(last_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner of the single cart memory bus
//
// Purpose: grants one requester at a time, issues its command on the cart bus,
// returns read data/ack to the owner and aborts reads the target never acks.
// Ports:
//   i_clk     system clock
//   i_reset   synchronous active-high reset
//   bus       bus_arbiter_if.master: requester commands/responses, bus command,
//             bus response and the o_timeout abort pulse
// Parameters: NUM_MASTERS (2..4), TIMEOUT (cycles from read acceptance to abort).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 1023
) (
    input logic           i_clk,
    input logic           i_reset,
    bus_arbiter_if.master bus
);

    localparam int N    = NUM_MASTERS;
    localparam int IW   = $clog2(N);
    localparam int WD_W = 10;

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;
    logic              write_q, write_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [N-1:0]      m_ack_q, m_ack_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              timeout_q, timeout_d;

    logic [N-1:0]      eligible;
    logic [N-1:0]      grant_vec;
    logic [IW-1:0]     win;
    logic              win_valid;

    function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] idx);
        to_onehot      = '0;
        to_onehot[idx] = 1'b1;
    endfunction

    assign eligible = bus.i_m_request & bus.i_enable;

    rr_priority_encoder #(.N(N), .IW(IW)) u_rr_pe (
        .eligible_i (eligible),
        .last_i     (last_q),
        .winner_o   (win),
        .valid_o    (win_valid)
    );

    // A command is taken only in IDLE; the winner sees busy low in that same cycle.
    assign grant_vec    = (state_q == IDLE && win_valid) ? to_onehot(win) : '0;
    assign bus.o_m_busy = ~grant_vec | {N{i_reset}};

    assign bus.o_request = (state_q == ISSUE);
    assign bus.o_write   = write_q;
    assign bus.o_bank    = bank_q;
    assign bus.o_address = addr_q;
    assign bus.o_data    = data_q;
    assign bus.o_m_ack   = m_ack_q;
    assign bus.o_m_data  = m_data_q;
    assign bus.o_timeout = timeout_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        write_d   = write_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wd_d      = wd_q;
        m_ack_d   = '0;
        m_data_d  = m_data_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    write_d = bus.i_m_write[win];
                    bank_d  = bus.i_m_bank[int'(win)*BANK_W +: BANK_W];
                    addr_d  = bus.i_m_address[int'(win)*ADDR_W +: ADDR_W];
                    data_d  = bus.i_m_data[int'(win)*DATA_W +: DATA_W];
                    owner_d = win;
                    last_d  = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.i_busy) begin
                    state_d = write_q ? IDLE : WAIT_ACK;
                    // The acceptance cycle counts as the first elapsed cycle, so the
                    // abort pulse lands exactly TIMEOUT cycles after acceptance.
                    wd_d    = WD_W'(1);
                end
            end
            WAIT_ACK: begin
                if (bus.i_ack) begin
                    m_ack_d  = to_onehot(owner_q);
                    m_data_d = bus.i_data;
                    state_d  = IDLE;
                end else if (wd_q + WD_W'(1) == WD_W'(TIMEOUT)) begin
                    m_ack_d   = to_onehot(owner_q);
                    m_data_d  = TIMEOUT_DATA;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= IW'(N - 1);
            write_q   <= 1'b0;
            bank_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wd_q      <= '0;
            m_ack_q   <= '0;
            m_data_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            write_q   <= write_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wd_q      <= wd_d;
            m_ack_q   <= m_ack_d;
            m_data_q  <= m_data_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_MASTERS(N)) bus();

    bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] req, en, wr;
    logic [3:0]   bk [N];
    logic [25:0]  ad [N];
    logic [31:0]  dt [N];

    int           model_last;
    int           last_w;
    logic [N-1:0] exp_ack;
    logic [31:0]  exp_data;
    logic         exp_to;
    logic [N-1:0] allones;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_masters();
        bus.i_m_request = req;
        bus.i_enable    = en;
        bus.i_m_write   = wr;
        for (int k = 0; k < N; k++) begin
            bus.i_m_bank[4*k +: 4]     = bk[k];
            bus.i_m_address[26*k +: 26] = ad[k];
            bus.i_m_data[32*k +: 32]   = dt[k];
        end
    endtask

    // Round-robin rule: first eligible index after the last grant, wrapping.
    function automatic int rr_pick(input logic [N-1:0] elig, input int last);
        for (int i = 1; i <= N; i++)
            if (elig[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic new_cmd(input int k);
        wr[k] = 1'($urandom);
        bk[k] = 4'($urandom);
        ad[k] = 26'($urandom);
        dt[k] = $urandom;
    endtask

    // One arbitration slot: the IDLE decision plus the whole transaction of the winner.
    // nb: busy cycles before acceptance; d: WAIT_ACK cycle carrying i_ack (>= TMO means never);
    // refill: 0 keep command, 1 new random command, 2 drop request after acceptance.
    task automatic run_slot(input int nb, input int d, input int refill, input bit noise,
                            input bit late_ack, input logic [31:0] rd);
        int           w;
        logic         cw;
        logic [3:0]   cb;
        logic [25:0]  ca;
        logic [31:0]  cd;
        logic [N-1:0] expbusy;
        logic [N-1:0] oh;
        bus.i_busy = 1'b0;
        bus.i_ack  = late_ack;
        drive_masters();
        @(negedge clk);
        w = rr_pick(req & en, model_last);
        expbusy = '1;
        if (w >= 0) expbusy[w] = 1'b0;
        check("idle_request", bus.o_request, 0);
        check("idle_m_ack", bus.o_m_ack, exp_ack);
        check("idle_timeout", bus.o_timeout, exp_to);
        if (exp_ack != 0) check("idle_m_data", bus.o_m_data, exp_data);
        check("grant_busy", bus.o_m_busy, expbusy);
        exp_ack = '0;
        exp_to  = 1'b0;
        last_w  = w;
        @(posedge clk); #1;
        bus.i_ack = 1'b0;
        if (w < 0) return;
        model_last = w;
        cw = wr[w]; cb = bk[w]; ca = ad[w]; cd = dt[w];
        oh = '0;
        oh[w] = 1'b1;
        if (refill == 1) begin
            req[w] = ($urandom % 4) != 0;
            new_cmd(w);
        end else if (refill == 2) begin
            req[w] = 1'b0;
        end
        for (int i = 0; i <= nb; i++) begin
            bus.i_busy = (i < nb);
            if (noise) begin
                bus.i_ack = 1'($urandom);
                en = N'($urandom);
            end
            drive_masters();
            @(negedge clk);
            check("issue_request", bus.o_request, 1);
            check("issue_write", bus.o_write, cw);
            check("issue_bank", bus.o_bank, cb);
            check("issue_addr", bus.o_address, ca);
            check("issue_data", bus.o_data, cd);
            check("issue_busy", bus.o_m_busy, allones);
            check("issue_m_ack", bus.o_m_ack, 0);
            @(posedge clk); #1;
        end
        bus.i_ack  = 1'b0;
        bus.i_busy = 1'b0;
        if (cw) return;
        for (int k = 1; k < TMO; k++) begin
            bus.i_ack  = (k == d);
            bus.i_data = (k == d) ? rd : $urandom;
            if (noise) begin
                bus.i_busy = 1'($urandom);
                en = N'($urandom);
                drive_masters();
            end
            @(negedge clk);
            check("wait_request", bus.o_request, 0);
            check("wait_m_ack", bus.o_m_ack, 0);
            check("wait_busy", bus.o_m_busy, allones);
            @(posedge clk); #1;
            if (k == d) begin
                exp_ack = oh; exp_data = rd; exp_to = 1'b0;
                break;
            end
            if (k == TMO - 1) begin
                exp_ack = oh; exp_data = 32'hFFFF_FFFF; exp_to = 1'b1;
            end
        end
        bus.i_ack  = 1'b0;
        bus.i_busy = 1'b0;
    endtask

    initial begin
        allones = '1;
        rst = 1'b1;
        req = '1; en = '1; wr = '0;
        for (int k = 0; k < N; k++) begin bk[k] = '0; ad[k] = '0; dt[k] = '0; end
        bus.i_busy = 1'b0; bus.i_ack = 1'b0; bus.i_data = '0;
        drive_masters();
        exp_ack = '0; exp_data = '0; exp_to = 1'b0;
        model_last = N - 1; last_w = -1;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_busy", bus.o_m_busy, allones);
        check("reset_request", bus.o_request, 0);
        check("reset_write", bus.o_write, 0);
        check("reset_bank", bus.o_bank, 0);
        check("reset_addr", bus.o_address, 0);
        check("reset_data", bus.o_data, 0);
        check("reset_m_data", bus.o_m_data, 0);
        check("reset_m_ack", bus.o_m_ack, 0);
        check("reset_timeout", bus.o_timeout, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Continuous writes from everybody: strict 0,1,2 rotation.
        for (int k = 0; k < N; k++) begin new_cmd(k); wr[k] = 1'b1; end
        req = '1;
        for (int i = 0; i < 6; i++) begin
            run_slot(0, 0, 0, 1'b0, 1'b0, 32'h0);
            check("rr_order", last_w, i % 3);
        end

        // Master 1 disabled: it is never granted.
        en = 3'b101;
        for (int i = 0; i < 4; i++) begin
            run_slot(0, 0, 0, 1'b0, 1'b0, 32'h0);
            check("en_order", last_w, (i % 2) * 2);
        end

        // Master 1 read held off 3 busy cycles, acked 5 cycles after acceptance.
        en = '1; req = '0;
        req[1] = 1'b1; wr[1] = 1'b0; bk[1] = 4'd2; ad[1] = 26'h000_1000;
        run_slot(3, 5, 2, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("read_owner", last_w, 1);

        // Read never acked: abort, then a late ack is ignored.
        req[0] = 1'b1; wr[0] = 1'b0;
        run_slot(0, 99, 2, 1'b0, 1'b0, 32'h0);
        run_slot(0, 0, 0, 1'b0, 1'b1, 32'h0);
        run_slot(0, 0, 0, 1'b0, 1'b0, 32'h0);

        // Ack on the abort cycle wins.
        req[2] = 1'b1; wr[2] = 1'b0;
        run_slot(1, TMO - 1, 2, 1'b0, 1'b0, 32'hCAFE_F00D);
        run_slot(0, 0, 0, 1'b0, 1'b0, 32'h0);

        // Reset while master 1 waits for read data.
        req = '0; req[1] = 1'b1; wr[1] = 1'b0;
        drive_masters();
        @(negedge clk);
        check("rst_grant", bus.o_m_busy, 3'b101);
        @(posedge clk); #1;
        req[1] = 1'b0; drive_masters();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req = '1; bus.i_ack = 1'b1; bus.i_data = 32'h1234_5678;
        drive_masters();
        @(negedge clk);
        check("rst_mid_busy", bus.o_m_busy, allones);
        @(posedge clk); #1;
        rst = 1'b0; req = '0; drive_masters();
        @(negedge clk);
        check("rst_drop_request", bus.o_request, 0);
        check("rst_no_ack_a", bus.o_m_ack, 0);
        @(posedge clk); #1;
        bus.i_ack = 1'b0;
        @(negedge clk);
        check("rst_no_ack_b", bus.o_m_ack, 0);
        @(posedge clk); #1;
        model_last = N - 1;
        for (int k = 0; k < N; k++) begin new_cmd(k); wr[k] = 1'b1; end
        req = '1;
        run_slot(0, 0, 0, 1'b0, 1'b0, 32'h0);
        check("post_reset_first", last_w, 0);

        // Randomized traffic.
        req = '0; en = '1;
        for (int s = 0; s < 200; s++) begin
            for (int k = 0; k < N; k++)
                if (!req[k] && ($urandom % 2 == 1)) begin req[k] = 1'b1; new_cmd(k); end
            if ($urandom % 5 == 0) en = N'($urandom);
            run_slot(int'($urandom % 4), 1 + int'($urandom % 9), 1, 1'b1,
                     1'($urandom), $urandom);
        end
        req = '0;
        run_slot(0, 0, 0, 1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
